// File: rtl/mult_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    md_mul_lo = 2'b00,
    md_mul_hi = 2'b01,
    md_div_q  = 2'b10,
    md_div_r  = 2'b11
  } lc3b_md_op;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } md_state_e;

  function automatic logic is_div(input lc3b_md_op op);
    return (op == md_div_q) || (op == md_div_r);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/busy/done handshake between the EX stage and the multiply/divide unit.
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             start;
  lc3b_md_op        op;
  logic             signed_en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op, signed_en, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, signed_en, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result fix-up.
module mult_div_unit_sign_fix #(
  parameter int WIDTH = 16
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? (~x + WIDTH'(1)) : x;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiply / restoring divide, one bit per cycle.
//   state | meaning
//   IDLE  | waiting for start; result/div_by_zero hold last value
//   RUN   | one multiply or divide iteration per cycle, counter counts down
//   FIN   | done pulse; result and div_by_zero were registered on entry
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave md
);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  lc3b_md_op          op_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [WIDTH-1:0]   opd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               dbz_q;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_nxt;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_top;
  logic [WIDTH:0]     div_diff;

  assign sign_a = md.signed_en & md.a[WIDTH-1];
  assign sign_b = md.signed_en & md.b[WIDTH-1];

  mult_div_unit_sign_fix #(.WIDTH(WIDTH))   u_mag_a (.neg(sign_a), .x(md.a), .y(mag_a));
  mult_div_unit_sign_fix #(.WIDTH(WIDTH))   u_mag_b (.neg(sign_b), .x(md.b), .y(mag_b));
  mult_div_unit_sign_fix #(.WIDTH(2*WIDTH)) u_prod  (.neg(sign_a_q ^ sign_b_q),
                                                     .x(acc_nxt), .y(prod_fix));
  mult_div_unit_sign_fix #(.WIDTH(WIDTH))   u_quo   (.neg(sign_a_q ^ sign_b_q),
                                                     .x(acc_nxt[WIDTH-1:0]), .y(quo_fix));
  mult_div_unit_sign_fix #(.WIDTH(WIDTH))   u_rem   (.neg(sign_a_q),
                                                     .x(acc_nxt[2*WIDTH-1:WIDTH]), .y(rem_fix));

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    div_top  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_top - {1'b0, opd};
    acc_nxt  = acc;
    if (is_div(op_q)) begin
      acc_nxt = {(div_diff[WIDTH] ? div_top[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                 acc[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    res_nxt = '0;
    case (op_q)
      md_mul_lo: res_nxt = prod_fix[WIDTH-1:0];
      md_mul_hi: res_nxt = prod_fix[2*WIDTH-1:WIDTH];
      md_div_q:  res_nxt = quo_fix;
      md_div_r:  res_nxt = rem_fix;
      default:   res_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= md_mul_lo;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opd      <= '0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (md.start) begin
            op_q     <= md.op;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            dbz_q    <= 1'b0;
            if (is_div(md.op) && (md.b == '0)) begin
              // divide by zero never iterates: all-ones quotient, dividend as remainder
              state    <= ST_FIN;
              done_q   <= 1'b1;
              dbz_q    <= 1'b1;
              result_q <= (md.op == md_div_q) ? '1 : md.a;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
              cnt    <= CNT_W'(WIDTH);
              opd    <= is_div(md.op) ? mag_b : mag_a;
              acc    <= {{WIDTH{1'b0}}, (is_div(md.op) ? mag_a : mag_b)};
            end
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= ST_FIN;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_nxt;
          end
        end
        ST_FIN: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md.busy        = busy_q;
  assign md.done        = done_q;
  assign md.result      = result_q;
  assign md.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Random and directed checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  mult_div_unit_if #(.WIDTH(W)) md_bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, truncating signed division
  task automatic model(input logic [1:0] op, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] res, output logic dbz);
    longint      p;
    logic [63:0] pv;
    int          ia, ib, q, r;
    dbz = 1'b0;
    if (op[1] == 1'b0) begin
      if (sg) p = longint'($signed(a)) * longint'($signed(b));
      else    p = longint'(a) * longint'(b);
      pv  = p;
      res = (op == 2'b00) ? pv[W-1:0] : pv[2*W-1:W];
    end else begin
      if (b == '0) begin
        dbz = 1'b1;
        q   = 32'hFFFF;
        r   = int'(a);
      end else if (sg) begin
        ia = int'($signed(a));
        ib = int'($signed(b));
        q  = ia / ib;
        r  = ia % ib;
      end else begin
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
      end
      res = (op == 2'b10) ? W'(q) : W'(r);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after done, which is IDLE again
  task automatic run_op(input logic [1:0] op, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int          cyc, busy_cnt, done_cyc;
    logic [W-1:0] exp_res;
    logic         exp_dbz;
    model(op, sg, a, b, exp_res, exp_dbz);
    md_bus.start     = 1'b1;
    md_bus.op        = lc3b_md_op'(op);
    md_bus.signed_en = sg;
    md_bus.a         = a;
    md_bus.b         = b;
    cyc = 0; busy_cnt = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 4 * W) begin
      @(negedge clk);
      cyc++;
      md_bus.start = 1'b0;
      md_bus.a     = W'($urandom);
      md_bus.b     = W'($urandom);
      if (md_bus.busy) busy_cnt++;
      if (md_bus.done) done_cyc = cyc;
    end
    check_eq("done_cycle", done_cyc, exp_dbz ? 1 : W + 1);
    check_eq("busy_cycles", busy_cnt, exp_dbz ? 0 : W);
    check_eq("result", md_bus.result, exp_res);
    check_eq("div_by_zero", md_bus.div_by_zero, exp_dbz);
    @(negedge clk);
    check_eq("done_pulse_width", md_bus.done, 1'b0);
    check_eq("busy_after_done", md_bus.busy, 1'b0);
    check_eq("result_held", md_bus.result, exp_res);
  endtask

  initial begin
    int           cyc, done_cyc, dones;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    reset = 1'b1;
    md_bus.start = 1'b0; md_bus.op = md_mul_lo; md_bus.signed_en = 1'b0;
    md_bus.a = '0; md_bus.b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_busy", md_bus.busy, 1'b0);
    check_eq("rst_done", md_bus.done, 1'b0);
    check_eq("rst_result", md_bus.result, '0);
    check_eq("rst_dbz", md_bus.div_by_zero, 1'b0);
    @(negedge clk);

    // Directed cases, back to back
    run_op(2'b00, 1'b0, 16'h0123, 16'h0045);
    check_eq("mul_lo_literal", md_bus.result, 16'h4E6F);
    run_op(2'b01, 1'b1, 16'hFFFF, 16'h0002);
    check_eq("smul_hi_literal", md_bus.result, 16'hFFFF);
    run_op(2'b00, 1'b1, 16'hFFFF, 16'h0002);
    check_eq("smul_lo_literal", md_bus.result, 16'hFFFE);
    run_op(2'b10, 1'b0, 16'd100, 16'd7);
    check_eq("udiv_q_literal", md_bus.result, 16'h000E);
    run_op(2'b11, 1'b0, 16'd100, 16'd7);
    check_eq("udiv_r_literal", md_bus.result, 16'h0002);
    run_op(2'b10, 1'b1, 16'hFFF9, 16'h0002);
    check_eq("sdiv_q_literal", md_bus.result, 16'hFFFD);
    run_op(2'b11, 1'b1, 16'hFFF9, 16'h0002);
    check_eq("sdiv_r_literal", md_bus.result, 16'hFFFF);
    run_op(2'b10, 1'b1, 16'h8000, 16'hFFFF);
    check_eq("ovf_q_literal", md_bus.result, 16'h8000);
    run_op(2'b11, 1'b1, 16'h8000, 16'hFFFF);
    check_eq("ovf_r_literal", md_bus.result, 16'h0000);
    run_op(2'b10, 1'b0, 16'h1234, 16'h0000);
    check_eq("dbz_q_literal", md_bus.result, 16'hFFFF);
    run_op(2'b11, 1'b1, 16'h1234, 16'h0000);
    check_eq("dbz_r_literal", md_bus.result, 16'h1234);
    run_op(2'b00, 1'b0, 16'h0003, 16'h0005);
    check_eq("dbz_cleared", md_bus.div_by_zero, 1'b0);

    // Random operations against the model
    for (int i = 0; i < 48; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rb  = W'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: rb = W'($urandom_range(1, 5));
        default: ;
      endcase
      run_op(rop, 1'($urandom_range(0, 1)), ra, rb);
    end

    // Start during RUN is ignored
    md_bus.start = 1'b1; md_bus.op = md_mul_lo; md_bus.signed_en = 1'b0;
    md_bus.a = 16'h0123; md_bus.b = 16'h0045;
    cyc = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 4 * W) begin
      @(negedge clk);
      cyc++;
      md_bus.start = (cyc == 5);
      if (cyc == 5) begin
        md_bus.op = md_div_q; md_bus.a = 16'h0005; md_bus.b = 16'h0000;
      end
      if (md_bus.done) done_cyc = cyc;
    end
    check_eq("ign_done_cycle", done_cyc, W + 1);
    check_eq("ign_result", md_bus.result, 16'h4E6F);
    check_eq("ign_dbz", md_bus.div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("ign_no_relaunch_busy", md_bus.busy, 1'b0);
    check_eq("ign_no_relaunch_done", md_bus.done, 1'b0);

    // Reset mid-operation aborts
    md_bus.start = 1'b1; md_bus.op = md_mul_hi; md_bus.signed_en = 1'b1;
    md_bus.a = 16'h7FFF; md_bus.b = 16'h7FFF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      md_bus.start = 1'b0;
    end
    check_eq("pre_rst_busy", md_bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", md_bus.busy, 1'b0);
    check_eq("abort_result", md_bus.result, '0);
    check_eq("abort_done", md_bus.done, 1'b0);
    reset = 1'b0;
    dones = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (md_bus.done || md_bus.busy) dones++;
    end
    check_eq("abort_no_done", dones, 0);

    run_op(2'b10, 1'b1, 16'hFF9C, 16'h0007);
    check_eq("post_rst_q_literal", md_bus.result, 16'hFFF2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
